// File: rtl/calu_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared combinational complex ALU.
// Holds operands for an opcode-dependent settle time, then registers the result.
module calu_issue_arbiter #(
    parameter int ALU_WAIT = 1,
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [31:0] req0_z1,
    input  logic [31:0] req0_z2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opcode,
    input  logic [31:0] req1_z1,
    input  logic [31:0] req1_z2,
    output logic [3:0]  calu_opcode,
    output logic [31:0] calu_z1,
    output logic [31:0] calu_z2,
    input  logic [31:0] calu_zout,
    input  logic [11:0] calu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_z,
    output logic [11:0] rsp_flags,
    output logic        busy,
    output logic        err_div,
    input  logic        err_clr
);

    localparam logic [3:0] OP_CMUL = 4'b0010;
    localparam logic [3:0] OP_CDIV = 4'b0011;
    localparam int MAX_AM   = (ALU_WAIT > MUL_WAIT) ? ALU_WAIT : MUL_WAIT;
    localparam int MAX_WAIT = (MAX_AM > DIV_WAIT) ? MAX_AM : DIV_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    logic          ptr;
    logic [CW-1:0] cnt;
    logic          grant_id;
    logic          grant_valid;
    logic          accept;
    logic [3:0]    sel_opcode;
    logic [31:0]   sel_z1;
    logic [31:0]   sel_z2;
    logic          err_set;

    function automatic logic [CW-1:0] wait_m1(input logic [3:0] op);
        unique case (op)
            OP_CMUL: wait_m1 = CW'(MUL_WAIT - 1);
            OP_CDIV: wait_m1 = CW'(DIV_WAIT - 1);
            default: wait_m1 = CW'(ALU_WAIT - 1);
        endcase
    endfunction

    // Pointer side wins when valid, otherwise the other side.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = ptr ? req1_valid : ~req0_valid;
    end

    assign req0_ready = ~rst && (state == IDLE) && grant_valid && ~grant_id;
    assign req1_ready = ~rst && (state == IDLE) && grant_valid && grant_id;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
    assign sel_z1     = grant_id ? req1_z1 : req0_z1;
    assign sel_z2     = grant_id ? req1_z2 : req0_z2;

    assign err_set = (state == EXEC) && (cnt == '0) &&
                     (calu_opcode == OP_CDIV) && (|calu_flags[9:6]);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            calu_opcode <= '0;
            calu_z1     <= '0;
            calu_z2     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_z       <= '0;
            rsp_flags   <= '0;
            err_div     <= 1'b0;
        end else begin
            if (err_set)
                err_div <= 1'b1;
            else if (err_clr)
                err_div <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        calu_opcode <= sel_opcode;
                        calu_z1     <= sel_z1;
                        calu_z2     <= sel_z2;
                        rsp_id      <= grant_id;
                        cnt         <= wait_m1(sel_opcode);
                        ptr         <= ~grant_id;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_z     <= calu_zout;
                        rsp_flags <= calu_flags;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
